multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multi-cycle main control unit. It is the producer side of the ALUop interface consumed by the ALU controller.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives ALUop with the decoded opcode during EXEC, plus PC, IR, register-file, stack-pointer and memory strobes.
- Sits between the instruction register and the datapath; handshakes with memory via mem_ready.

Parameters:
- OP_W, 6, opcode and ALUop width
- ALU_IDLE, 6'b111111, ALUop value driven outside EXEC (ALU "do nothing")

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  6  instruction bits [31:26], valid from the IR in DECODE
- mem_ready  input  1  memory completes current read/write this cycle
- flag_zero  input  1  ALU zero flag, sampled in EXEC
- flag_neg  input  1  ALU negative flag, sampled in EXEC
- ALUop  output  6  to ALU controller
- ir_write  output  1  load IR from memory data
- pc_write  output  1  update PC
- pc_src  output  2  00 PC+4, 01 branch/jump target (ALU result), 10 memory data (RET)
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- iord  output  1  0 = address from PC, 1 = address from ALU/SP
- alu_src  output  1  0 = rt, 1 = sign-extended immediate
- reg_write  output  1  register-file write
- mem_to_reg  output  1  writeback from memory data instead of ALU
- sp_write  output  1  update stack pointer
- illegal_op  output  1  one-cycle pulse on undecodable opcode
- halted  output  1  high while in HALT
- state  output  3  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Any other value goes to FETCH on the next cycle.
- Outputs are combinational from the registered state, the latched opcode op_q, and mem_ready.
- All strobes default to 0. ALUop defaults to ALU_IDLE.
- Reset:
  - rst high at a clock edge sets state=FETCH and op_q=0.
  - While rst is high, all strobes are forced to 0 and ALUop=ALU_IDLE.
  - Reset mid-operation aborts immediately. No write strobe asserts in the cycle rst is high.
- FETCH:
  - mem_read=1, iord=0.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE. Otherwise hold.
- DECODE:
  - op_q <= opcode.
  - Legal opcodes: 0–22 and 32. Opcode 32 (HALT) goes to HALT. Other legal opcodes go to EXEC.
  - Illegal opcode: illegal_op=1, go to FETCH (treated as NOP).
- EXEC: ALUop=op_q.
  - Opcodes 1–9: alu_src=1.
  - Opcodes 10–13: alu_src=1.
  - Opcodes 0, 1–9, 22 (MOVE): go to WB.
  - LD(10), LDSP(12), POP(19), RET(21): go to MEM (read).
  - ST(11), STSP(13), PUSH(18), CALL(20): go to MEM (write).
  - BR(14): pc_write=1, pc_src=01, go to FETCH.
  - BMI(15): pc_write=flag_neg. BPL(16): pc_write=~flag_neg. BZ(17): pc_write=flag_zero. All three use pc_src=01, then go to FETCH.
- MEM:
  - iord=1. mem_read=1 for 10/12/19/21; mem_write=1 for 11/13/18/20. The strobe holds until mem_ready.
  - When mem_ready:
    - 10/12/19: go to WB.
    - 11/13: go to FETCH.
    - 18: sp_write=1, go to FETCH.
    - 20: sp_write=1, pc_write=1, pc_src=01, go to FETCH.
    - 21: sp_write=1, pc_write=1, pc_src=10, go to FETCH.
- WB:
  - reg_write=1.
  - mem_to_reg=1 for 10/12/19.
  - sp_write=1 for 19.
  - Go to FETCH.
- HALT: halted=1, all strobes 0. Exit only via rst.
- Simultaneous events:
  - mem_ready outside FETCH/MEM is ignored.
  - Flags are sampled only in EXEC.
- Latency, with mem_ready=1 in the same cycle it is requested:
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store/branch: 3–4 cycles.

Test Plan:
- Reset then opcode=1 (ADDI), mem_ready=1 always -> states 0,1,2,4,0. In EXEC: ALUop=000001, alu_src=1. reg_write=1 only in WB.
- opcode=0 (R-type) -> ALUop=000000 in EXEC and ALUop=111111 in all other states; reg_write in WB.
- BZ: opcode=17 with flag_zero=1 -> pc_write=1, pc_src=01 in EXEC. Repeat with flag_zero=0 -> pc_write=0. Both return to FETCH.
- LD (10) with mem_ready low for 3 cycles in MEM -> mem_read=1, iord=1 held for 4 cycles, then WB with mem_to_reg=1, reg_write=1.
- Opcode 32 -> HALT, halted=1 stays high for 10+ cycles. rst=1 -> FETCH, halted=0, mem_read=1.
- rst asserted during MEM of ST (11) -> mem_write=0 in the reset cycle, FETCH next. Opcode 40 in DECODE -> illegal_op single-cycle pulse, then FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main control unit: sequences FETCH/DECODE/EXEC/MEM/WB and
// produces ALUop plus the PC, IR, register-file, SP and memory strobes.
module multicycle_control_fsm #(
  parameter int              OP_W     = 6,
  parameter logic [OP_W-1:0] ALU_IDLE = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  input  logic            flag_zero,
  input  logic            flag_neg,
  output logic [OP_W-1:0] ALUop,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            iord,
  output logic            alu_src,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            sp_write,
  output logic            illegal_op,
  output logic            halted,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [OP_W-1:0] OP_LD   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LDSP = OP_W'(12);
  localparam logic [OP_W-1:0] OP_STSP = OP_W'(13);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(14);
  localparam logic [OP_W-1:0] OP_BMI  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_BPL  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_BZ   = OP_W'(17);
  localparam logic [OP_W-1:0] OP_PUSH = OP_W'(18);
  localparam logic [OP_W-1:0] OP_POP  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_CALL = OP_W'(20);
  localparam logic [OP_W-1:0] OP_RET  = OP_W'(21);
  localparam logic [OP_W-1:0] OP_MOVE = OP_W'(22);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(32);

  state_t          st_q, st_d;
  logic [OP_W-1:0] op_q;
  logic            is_alu, is_rd, is_wr, is_ldwb, legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= FETCH;
      op_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == DECODE) op_q <= opcode;
    end
  end

  // Instruction classes derived from the latched opcode.
  assign is_alu  = (op_q <= OP_W'(9)) || (op_q == OP_MOVE);
  assign is_ldwb = (op_q == OP_LD) || (op_q == OP_LDSP) || (op_q == OP_POP);
  assign is_rd   = is_ldwb || (op_q == OP_RET);
  assign is_wr   = (op_q == OP_ST) || (op_q == OP_STSP) ||
                   (op_q == OP_PUSH) || (op_q == OP_CALL);
  assign legal   = (opcode <= OP_W'(22)) || (opcode == OP_HALT);
  assign state   = st_q;

  always_comb begin
    st_d       = st_q;
    ALUop      = ALU_IDLE;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    sp_write   = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (st_q)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          st_d     = DECODE;
        end
      end
      DECODE: begin
        if (opcode == OP_HALT) st_d = HALT;
        else if (legal)        st_d = EXEC;
        else begin
          illegal_op = 1'b1;
          st_d       = FETCH;
        end
      end
      EXEC: begin
        ALUop   = op_q;
        alu_src = (op_q >= OP_W'(1)) && (op_q <= OP_STSP);
        if (is_alu)              st_d = WB;
        else if (is_rd || is_wr) st_d = MEM;
        else begin
          st_d = FETCH;
          if (op_q >= OP_BR && op_q <= OP_BZ) pc_src = 2'b01;
          case (op_q)
            OP_BR:   pc_write = 1'b1;
            OP_BMI:  pc_write = flag_neg;
            OP_BPL:  pc_write = ~flag_neg;
            OP_BZ:   pc_write = flag_zero;
            default: pc_write = 1'b0;
          endcase
        end
      end
      MEM: begin
        iord      = 1'b1;
        mem_read  = is_rd;
        mem_write = is_wr;
        if (!(is_rd || is_wr)) st_d = FETCH;
        else if (mem_ready) begin
          st_d = is_ldwb ? WB : FETCH;
          sp_write = (op_q == OP_PUSH) || (op_q == OP_CALL) || (op_q == OP_RET);
          if (op_q == OP_CALL) begin
            pc_write = 1'b1;
            pc_src   = 2'b01;
          end else if (op_q == OP_RET) begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
          end
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ldwb;
        sp_write   = (op_q == OP_POP);
        st_d       = FETCH;
      end
      HALT:    halted = 1'b1;
      default: st_d = FETCH;
    endcase
    // Reset aborts in the same cycle: nothing may be written while rst is high.
    if (rst) begin
      ALUop      = ALU_IDLE;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      sp_write   = 1'b0;
      illegal_op = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each instruction is expanded into its
// expected per-cycle output trace and compared cycle by cycle.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0, flag_zero = 1'b0, flag_neg = 1'b0;
  logic [5:0] ALUop;
  logic       ir_write, pc_write, mem_read, mem_write, iord, alu_src;
  logic       reg_write, mem_to_reg, sp_write, illegal_op, halted;
  logic [1:0] pc_src;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] aluop;
    logic       ir_write, pc_write;
    logic [1:0] pc_src;
    logic       mem_read, mem_write, iord, alu_src, reg_write;
    logic       mem_to_reg, sp_write, illegal_op, halted;
  } obs_t;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .flag_zero(flag_zero), .flag_neg(flag_neg), .ALUop(ALUop),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .alu_src(alu_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .sp_write(sp_write), .illegal_op(illegal_op), .halted(halted),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic obs_t idle(input logic [2:0] s);
    obs_t e;
    e       = '0;
    e.st    = s;
    e.aluop = 6'h3f;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom_range(63));
  endfunction

  // Apply one cycle of inputs at the falling edge, then check outputs.
  task automatic step(input logic r, input obs_t e, input logic mr,
                      input logic [5:0] opc, input logic fz, input logic fn,
                      input string tag);
    obs_t o;
    @(negedge clk);
    rst = r; mem_ready = mr; opcode = opc; flag_zero = fz; flag_neg = fn;
    #1;
    o = {state, ALUop, ir_write, pc_write, pc_src, mem_read, mem_write, iord,
         alu_src, reg_write, mem_to_reg, sp_write, illegal_op, halted};
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic do_fetch(input int w);
    obs_t e;
    e = idle(3'd0);
    e.mem_read = 1'b1;
    for (int i = 0; i < w; i++) step(1'b0, e, 1'b0, r6(), rb(), rb(), "fetch_wait");
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    step(1'b0, e, 1'b1, r6(), rb(), rb(), "fetch_done");
  endtask

  task automatic do_decode(input logic [5:0] op);
    obs_t e;
    e = idle(3'd1);
    e.illegal_op = !((op <= 6'd22) || (op == 6'd32));
    step(1'b0, e, rb(), op, rb(), rb(), "decode");
  endtask

  task automatic do_exec(input logic [5:0] op, input logic fz, input logic fn);
    obs_t e;
    e = idle(3'd2);
    e.aluop   = op;
    e.alu_src = (op >= 6'd1) && (op <= 6'd13);
    if (op >= 6'd14 && op <= 6'd17) begin
      e.pc_src = 2'b01;
      case (op)
        6'd14:   e.pc_write = 1'b1;
        6'd15:   e.pc_write = fn;
        6'd16:   e.pc_write = !fn;
        default: e.pc_write = fz;
      endcase
    end
    step(1'b0, e, rb(), r6(), fz, fn, "exec");
  endtask

  task automatic do_instr(input logic [5:0] op, input int fw, input int mw,
                          input logic fz, input logic fn);
    obs_t e;
    logic rd, wr;
    do_fetch(fw);
    do_decode(op);
    if (!((op <= 6'd22) || (op == 6'd32))) return;
    if (op == 6'd32) begin
      e = idle(3'd5);
      e.halted = 1'b1;
      for (int i = 0; i < 12; i++) step(1'b0, e, rb(), r6(), rb(), rb(), "halt");
      step(1'b1, idle(3'd5), rb(), r6(), rb(), rb(), "halt_rst");
      return;
    end
    do_exec(op, fz, fn);
    if (op >= 6'd14 && op <= 6'd17) return;
    rd = (op == 6'd10) || (op == 6'd12) || (op == 6'd19) || (op == 6'd21);
    wr = (op == 6'd11) || (op == 6'd13) || (op == 6'd18) || (op == 6'd20);
    if (rd || wr) begin
      e = idle(3'd3);
      e.iord = 1'b1; e.mem_read = rd; e.mem_write = wr;
      for (int i = 0; i < mw; i++) step(1'b0, e, 1'b0, r6(), rb(), rb(), "mem_wait");
      e.sp_write = (op == 6'd18) || (op == 6'd20) || (op == 6'd21);
      if (op == 6'd20) begin e.pc_write = 1'b1; e.pc_src = 2'b01; end
      if (op == 6'd21) begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
      step(1'b0, e, 1'b1, r6(), rb(), rb(), "mem_done");
      if (!((op == 6'd10) || (op == 6'd12) || (op == 6'd19))) return;
    end
    e = idle(3'd4);
    e.reg_write  = 1'b1;
    e.mem_to_reg = (op == 6'd10) || (op == 6'd12) || (op == 6'd19);
    e.sp_write   = (op == 6'd19);
    step(1'b0, e, rb(), r6(), rb(), rb(), "wb");
  endtask

  initial begin
    obs_t e;
    int   r;
    logic [5:0] op;
    // Reset: first rising edge loads FETCH; outputs stay quiet while rst is high.
    step(1'b1, idle(3'd0), 1'b1, 6'd0, 1'b0, 1'b0, "reset");
    step(1'b1, idle(3'd0), 1'b1, 6'd0, 1'b0, 1'b0, "reset_hold");

    do_instr(6'd1,  0, 0, 1'b0, 1'b0);   // ADDI
    do_instr(6'd0,  0, 0, 1'b1, 1'b1);   // R-type
    do_instr(6'd17, 0, 0, 1'b1, 1'b0);   // BZ taken
    do_instr(6'd17, 0, 0, 1'b0, 1'b1);   // BZ not taken
    do_instr(6'd10, 0, 3, 1'b0, 1'b0);   // LD with memory wait
    do_instr(6'd20, 2, 1, 1'b0, 1'b0);   // CALL
    do_instr(6'd21, 0, 0, 1'b0, 1'b0);   // RET
    do_instr(6'd19, 0, 0, 1'b0, 1'b0);   // POP
    do_instr(6'd32, 0, 0, 1'b0, 1'b0);   // HALT then reset

    // Reset in the middle of a store's memory phase.
    do_fetch(0);
    do_decode(6'd11);
    do_exec(6'd11, 1'b0, 1'b0);
    e = idle(3'd3);
    e.iord = 1'b1; e.mem_write = 1'b1;
    step(1'b0, e, 1'b0, r6(), 1'b0, 1'b0, "st_mem_wait");
    step(1'b1, idle(3'd3), 1'b1, r6(), 1'b0, 1'b0, "st_mem_rst");

    do_instr(6'd40, 0, 0, 1'b0, 1'b0);   // illegal opcode
    do_instr(6'd22, 1, 0, 1'b0, 1'b0);   // MOVE right after the illegal pulse

    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 49));
      if (r == 0)      op = 6'd32;
      else if (r < 5)  op = (r < 3) ? 6'($urandom_range(23, 31)) : 6'($urandom_range(33, 63));
      else             op = 6'($urandom_range(0, 22));
      do_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb(), rb());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
